// File: rtl/sample_fetch.sv
// sample_fetch: reads `len` consecutive samples from a synchronous RAM starting
// at `src_addr` and streams them out over valid/ready. A 2-entry buffer hides
// the 1-cycle RAM read latency so one sample per cycle is sustained.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, src_addr, len  transfer request (sampled/latched only in IDLE)
//   busy, done            busy while fetching; done pulses for one cycle at end
//   mem_rd_en, mem_addr   read strobe/address to the RAM
//   mem_rdata             RAM data, valid the cycle after mem_rd_en
//   out_data, out_valid   sample stream from the buffer head
//   out_ready, out_last   consumer handshake; out_last marks the final sample
module sample_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  popped_q, popped_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic              pop;
  logic              rd_en;
  logic              head_is_last;
  logic [1:0]        used_after_pop;
  logic [1:0]        wpos;

  // Buffer entry 0 is always the head; out_data/out_valid come straight from
  // registers, never from mem_rdata.
  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = buf0_q;
  assign pop          = out_valid && out_ready;
  assign head_is_last = (popped_q == len_q - LEN_W'(1));
  assign out_last     = out_valid && head_is_last;

  // occ >= pop whenever pop is high, so this never underflows.
  assign used_after_pop = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_en = (state_q == S_FETCH) && (issued_q < len_q) && (used_after_pop < 2'd2);

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? (src_q + ADDR_W'(issued_q)) : '0;
  assign busy      = (state_q == S_FETCH);
  assign done      = (state_q == S_FINISH);

  // Returning data lands behind whatever survives this cycle's pop.
  assign wpos = occ_q - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    occ_d      = occ_q;
    inflight_d = 1'b0;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d    = src_addr;
          len_d    = len;
          issued_d = '0;
          popped_d = '0;
          occ_d    = '0;
          buf0_d   = '0;
          buf1_d   = '0;
          state_d  = (len == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        inflight_d = rd_en;
        if (rd_en) begin
          issued_d = issued_q + LEN_W'(1);
        end
        if (pop) begin
          popped_d = popped_q + LEN_W'(1);
          buf0_d   = buf1_q;
        end
        if (inflight_q) begin
          if (wpos == 2'd0) begin
            buf0_d = mem_rdata;
          end else begin
            buf1_d = mem_rdata;
          end
        end
        occ_d = used_after_pop;
        if (pop && head_is_last) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_sample_fetch.sv
module tb_sample_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] mem [0:255];

  logic [8:0] exp_q [$];   // {last, data}
  logic [7:0] addr_q [$];

  int nvec = 0;
  int nerr = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;

  sample_fetch #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) valid_cnt++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", out_data, 9'h100);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e[7:0]);
          chk("sb_last", out_last, e[8]);
        end
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          chk("unexpected_read", mem_addr, 9'h100);
        end else begin
          chk("sb_addr", mem_addr, addr_q.pop_front());
        end
        chk("reads_ahead_le2", (rd_cnt - hs_cnt) <= 2, 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start in cycle 0; returns 1 time unit into cycle 1.
  task automatic do_start(input logic [7:0] s, input logic [7:0] l);
    logic [7:0] a;
    tick();
    start = 1'b1;
    src_addr = s;
    len = l;
    for (int k = 0; k < int'(l); k++) begin
      a = s + k[7:0];
      exp_q.push_back({(k == int'(l) - 1), mem[a]});
      addr_q.push_back(a);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (done) break;
      tick();
    end
    if (i == bound) chk("done_timeout", 0, 1);
    tick();
    chk("queue_drained", exp_q.size() + addr_q.size(), 0);
  endtask

  int d0;
  int r0;
  int v0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 10);
    rst_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    len = '0;
    out_ready = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Basic: src=0 len=4, cycle-accurate checks
    d0 = done_cnt;
    do_start(8'd0, 8'd4);
    for (int c = 1; c <= 7; c++) begin
      chk("b_rd_en", mem_rd_en, (c <= 4));
      if (c <= 4) chk("b_addr", mem_addr, c - 1);
      chk("b_valid", out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("b_data", out_data, c + 7);
      chk("b_last", out_last, (c == 6));
      chk("b_done", done, (c == 7));
      chk("b_busy", busy, (c <= 6));
      tick();
    end
    chk("b_done_once", done_cnt - d0, 1);
    chk("b_drained", exp_q.size(), 0);

    // Zero length
    d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
    do_start(8'd7, 8'd0);
    chk("z_done_c1", done, 1);
    chk("z_busy_c1", busy, 0);
    for (int c = 0; c < 4; c++) tick();
    chk("z_no_reads", rd_cnt - r0, 0);
    chk("z_no_valid", valid_cnt - v0, 0);
    chk("z_done_once", done_cnt - d0, 1);

    // Backpressure: ready alternating, then held low 5 cycles
    d0 = done_cnt;
    do_start(8'd50, 8'd8);
    for (int i = 0; i < 60; i++) begin
      out_ready = (i < 10) ? (i % 2 == 0) : ((i < 15) ? 1'b0 : 1'b1);
      tick();
      if (done) break;
    end
    out_ready = 1'b1;
    wait_done(5);
    chk("bp_done_once", done_cnt - d0, 1);

    // Wrap-around
    d0 = done_cnt;
    do_start(8'd254, 8'd4);
    wait_done(20);
    chk("w_done_once", done_cnt - d0, 1);

    // Start while busy is ignored
    d0 = done_cnt;
    do_start(8'd30, 8'd5);
    tick();
    tick();
    start = 1'b1; src_addr = 8'd100; len = 8'd2;
    tick();
    start = 1'b0;
    wait_done(20);
    tick();
    tick();
    chk("sb_done_once", done_cnt - d0, 1);
    chk("sb_idle_after", busy, 0);

    // Reset mid-transfer
    do_start(8'd40, 8'd10);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_rd_en", mem_rd_en, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_last", out_last, 0);
    chk("mr_data", out_data, 0);
    chk("mr_addr", mem_addr, 0);
    exp_q.delete();
    addr_q.delete();
    rd_cnt = hs_cnt;
    tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    do_start(8'd20, 8'd2);
    wait_done(20);
    chk("mr_done_once", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
